mem_wb_stage: RTL and testbench

//  Stage directly downstream of the ALU: latches the ALU result and flags, runs LD/ST data-memory

---
 rtl/mem_wb_stage_pkg.sv | 68 ++++++
 rtl/mem_wb_stage.sv | 127 ++++++++++++
 tb/tb_mem_wb_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_pkg.sv
// ============================================================================
// mem_wb_stage_pkg : opcode classes, FSM state type and decode helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_wb_stage_pkg;

   // Opcode class lives in ir[31:16]
   localparam logic [15:0] OP_NOP  = 16'h0000;
   localparam logic [15:0] OP_LIL  = 16'h0001;
   localparam logic [15:0] OP_MOV  = 16'h0002;
   localparam logic [15:0] OP_ADD  = 16'h0003;
   localparam logic [15:0] OP_SUB  = 16'h0004;
   localparam logic [15:0] OP_AND  = 16'h0005;
   localparam logic [15:0] OP_OR   = 16'h0006;
   localparam logic [15:0] OP_XOR  = 16'h0007;
   localparam logic [15:0] OP_ADDI = 16'h0008;
   localparam logic [15:0] OP_SUBI = 16'h0009;
   localparam logic [15:0] OP_ANDI = 16'h000A;
   localparam logic [15:0] OP_ORI  = 16'h000B;
   localparam logic [15:0] OP_XORI = 16'h000C;
   localparam logic [15:0] OP_NEG  = 16'h000D;
   localparam logic [15:0] OP_NOT  = 16'h000E;
   localparam logic [15:0] OP_SLL  = 16'h000F;
   localparam logic [15:0] OP_SLA  = 16'h0010;
   localparam logic [15:0] OP_SRL  = 16'h0011;
   localparam logic [15:0] OP_SRA  = 16'h0012;
   localparam logic [15:0] OP_LD   = 16'h0013;
   localparam logic [15:0] OP_ST   = 16'h0014;
   localparam logic [15:0] OP_CMP  = 16'h0015;
   localparam logic [15:0] OP_CMPI = 16'h0016;
   localparam logic [15:0] OP_B    = 16'h0017;
   localparam logic [15:0] OP_BCC  = 16'h0018;
   localparam logic [15:0] OP_JALR = 16'h0019;
   localparam logic [15:0] OP_RET  = 16'h001A;
   localparam logic [15:0] OP_JR   = 16'h001B;
   localparam logic [15:0] OP_PUSH = 16'h001C;
   localparam logic [15:0] OP_POP  = 16'h001D;
   localparam logic [15:0] OP_HLT  = 16'h001F;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MEM  = 2'd1,
      S_WB   = 2'd2,
      S_HALT = 2'd3
   } state_t;

   // Ops that end in a register-file write (LD writes after its memory phase)
   function automatic logic is_wb(input logic [15:0] op);
      logic r;
      r = 1'b0;
      case (op)
         OP_LIL, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
         OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_NEG, OP_NOT,
         OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_LD: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_mem(input logic [15:0] op);
      return (op == OP_LD) || (op == OP_ST);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// mem_wb_stage : latches ALU results, runs LD/ST over req/ack, drives the
//                register-file write port, holds flags and halt state.
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   output logic        ready_in,
   input  logic [31:0] ir_in,
   input  logic [2:0]  rd_in,
   input  logic [31:0] dr_in,
   input  logic [31:0] st_data,
   input  logic [4:0]  flags_in,
   input  logic        flag_up,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        wb_en,
   output logic [2:0]  wb_idx,
   output logic [31:0] wb_data,
   output logic [4:0]  flags,
   output logic        halted,
   output logic        mem_err
);

   state_t            r_state;
   state_t            w_next;
   logic [15:0]       r_op;
   logic [2:0]        r_rd;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_result;
   logic [TO_W-1:0]   r_cnt;
   logic [4:0]        r_flags;
   logic              r_err;
   logic              w_accept;
   logic              w_expire;
   logic [15:0]       w_op_in;
   logic              w_unused;

   assign w_op_in  = ir_in[31:16];
   assign w_unused = ^ir_in[15:0];
   assign ready_in = (r_state == S_IDLE);
   assign w_accept = valid_in && ready_in;
   // Last permitted MEM cycle; an ack arriving now still completes normally
   assign w_expire = (r_cnt == TO_W'(MEM_TIMEOUT - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (is_mem(w_op_in))      w_next = S_MEM;
               else if (is_wb(w_op_in))  w_next = S_WB;
               else if (w_op_in == OP_HLT) w_next = S_HALT;
            end
         end
         S_MEM: begin
            if (mem_ack)       w_next = (r_op == OP_LD) ? S_WB : S_IDLE;
            else if (w_expire) w_next = S_IDLE;
         end
         S_WB:    w_next = S_IDLE;
         S_HALT:  w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_rd     <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_flags  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op     <= w_op_in;
            r_rd     <= rd_in;
            r_addr   <= dr_in;
            r_wdata  <= st_data;
            r_result <= dr_in;
            r_cnt    <= '0;
            if (flag_up) r_flags <= flags_in;
         end
         if (r_state == S_MEM) begin
            if (mem_ack) begin
               if (r_op == OP_LD) r_result <= mem_rdata;
            end else if (w_expire) begin
               r_err <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign mem_req   = (r_state == S_MEM);
   assign mem_we    = (r_state == S_MEM) && (r_op == OP_ST);
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign wb_en     = (r_state == S_WB);
   assign wb_idx    = (r_state == S_WB) ? r_rd : 3'd0;
   assign wb_data   = (r_state == S_WB) ? r_result : 32'd0;
   assign flags     = r_flags;
   assign halted    = (r_state == S_HALT);
   assign mem_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// tb_mem_wb_stage : scoreboard bench for mem_wb_stage
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;
   import mem_wb_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_in = 1'b0;
   logic        ready_in;
   logic [31:0] ir_in = '0;
   logic [2:0]  rd_in = '0;
   logic [31:0] dr_in = '0;
   logic [31:0] st_data = '0;
   logic [4:0]  flags_in = '0;
   logic        flag_up = 1'b0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        wb_en;
   logic [2:0]  wb_idx;
   logic [31:0] wb_data;
   logic [4:0]  flags;
   logic        halted;
   logic        mem_err;

   mem_wb_stage #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
      .ir_in(ir_in), .rd_in(rd_in), .dr_in(dr_in), .st_data(st_data),
      .flags_in(flags_in), .flag_up(flag_up), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_en(wb_en),
      .wb_idx(wb_idx), .wb_data(wb_data), .flags(flags),
      .halted(halted), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  idx;
      logic [31:0] data;
   } wb_exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          len;
   } mem_exp_t;

   wb_exp_t  wb_q[$];
   mem_exp_t mem_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one instruction; returns 1ns after the accepting edge
   task automatic issue(input logic [15:0] op, input logic [2:0] rd, input logic [31:0] dr,
                        input logic [31:0] sd, input logic [4:0] fl, input logic fu);
      int budget;
      budget = 0;
      while (!ready_in && budget < 50) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!ready_in) check("issue_ready_timeout", 32'(ready_in), 32'd1);
      valid_in = 1'b1;
      ir_in    = {op, 16'h00AB};
      rd_in    = rd;
      dr_in    = dr;
      st_data  = sd;
      flags_in = fl;
      flag_up  = fu;
      @(posedge clk); #1;
      valid_in = 1'b0;
      flag_up  = 1'b0;
      flags_in = 5'b11111;
   endtask

   // Monitor: pops expected writebacks / memory requests as the DUT presents them
   initial begin : monitor
      bit       prev_req;
      int       cnt;
      mem_exp_t cur;
      wb_exp_t  e;
      prev_req = 1'b0;
      cnt = 0;
      cur = '{we: 1'b0, addr: 32'd0, wdata: 32'd0, len: 0};
      forever begin
         @(negedge clk);
         if (wb_en) begin
            if (wb_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
            else begin
               e = wb_q.pop_front();
               check("wb_idx", 32'(wb_idx), 32'(e.idx));
               check("wb_data", wb_data, e.data);
            end
         end
         if (mem_req && !prev_req) begin
            if (mem_q.size() == 0) check("mem_unexpected", 32'd1, 32'd0);
            else begin
               cur = mem_q.pop_front();
               check("mem_we", 32'(mem_we), 32'(cur.we));
               check("mem_addr", mem_addr, cur.addr);
               check("mem_wdata", mem_wdata, cur.wdata);
            end
            cnt = 1;
         end else if (mem_req) begin
            cnt++;
            check("mem_stable", {mem_addr ^ cur.addr} | {mem_wdata ^ cur.wdata} | 32'(mem_we ^ cur.we), 32'd0);
         end else if (prev_req) begin
            check("mem_req_len", 32'(cnt), 32'(cur.len));
         end
         prev_req = mem_req;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      check("rst_ready", 32'(ready_in), 32'd1);
      check("rst_outs", {mem_addr | mem_wdata | wb_data}, 32'd0);
      check("rst_bits", {26'd0, wb_en, mem_req, mem_we, halted, mem_err, |wb_idx}, 32'd0);
      check("rst_flags", 32'(flags), 32'd0);

      // ALU op: writeback the cycle after accept, flags updated on accept
      wb_q.push_back('{idx: 3'd3, data: 32'h5});
      issue(OP_ADD, 3'd3, 32'h5, 32'h0, 5'b01000, 1'b1);
      check("add_flags", 32'(flags), 32'(5'b01000));
      check("add_busy", 32'(ready_in), 32'd0);
      @(posedge clk); #1;
      check("add_ready", 32'(ready_in), 32'd1);

      // LD with ack after 3 request cycles
      mem_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'hAAAA5555, len: 3});
      wb_q.push_back('{idx: 3'd1, data: 32'hDEADBEEF});
      issue(OP_LD, 3'd1, 32'h100, 32'hAAAA5555, 5'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      check("ld_wb_busy", 32'(ready_in), 32'd0);
      @(posedge clk); #1;

      // ST with ack in the first request cycle; no writeback
      mem_q.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'h12345678, len: 1});
      issue(OP_ST, 3'd2, 32'h40, 32'h12345678, 5'b0, 1'b0);
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("st_ready_after_ack", 32'(ready_in), 32'd1);

      // Stray ack while idle
      mem_ack = 1'b1; mem_rdata = 32'h99;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      check("stray_ack_idle", 32'(ready_in), 32'd1);

      // LD acked on the last permitted cycle completes normally
      mem_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0, len: 16});
      wb_q.push_back('{idx: 3'd6, data: 32'hCAFEF00D});
      issue(OP_LD, 3'd6, 32'h200, 32'h0, 5'b0, 1'b0);
      repeat (15) @(posedge clk);
      #1 mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      check("ack_at_expiry_err", 32'(mem_err), 32'd0);
      @(posedge clk); #1;

      // LD without ack times out after 16 request cycles
      mem_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, len: 16});
      issue(OP_LD, 3'd7, 32'h300, 32'h0, 5'b0, 1'b0);
      repeat (15) @(posedge clk);
      #1 check("timeout_req_held", 32'(mem_req), 32'd1);
      check("timeout_err_early", 32'(mem_err), 32'd0);
      @(posedge clk); #1;
      check("timeout_req_drop", 32'(mem_req), 32'd0);
      check("timeout_err", 32'(mem_err), 32'd1);
      check("timeout_ready", 32'(ready_in), 32'd1);

      // MOV without flag_up leaves flags alone
      wb_q.push_back('{idx: 3'd2, data: 32'h77});
      issue(OP_MOV, 3'd2, 32'h77, 32'h0, 5'b11111, 1'b0);
      check("mov_flags_kept", 32'(flags), 32'(5'b01000));
      @(posedge clk); #1;

      // CMP updates flags only; NOP does nothing
      issue(OP_CMP, 3'd4, 32'h1234, 32'h0, 5'b00110, 1'b1);
      check("cmp_flags", 32'(flags), 32'(5'b00110));
      check("cmp_stays_idle", 32'(ready_in), 32'd1);
      issue(OP_NOP, 3'd5, 32'h55, 32'h0, 5'b0, 1'b0);
      check("nop_idle", 32'(ready_in), 32'd1);

      // HLT: halted sticks and no further accepts
      issue(OP_HLT, 3'd0, 32'h0, 32'h0, 5'b0, 1'b0);
      check("hlt_halted", 32'(halted), 32'd1);
      check("hlt_ready", 32'(ready_in), 32'd0);
      valid_in = 1'b1; ir_in = {OP_ADD, 16'h0}; rd_in = 3'd1; dr_in = 32'h42;
      mem_ack = 1'b1;
      repeat (4) @(posedge clk);
      #1 valid_in = 1'b0; mem_ack = 1'b0;
      check("hlt_still_halted", 32'(halted), 32'd1);
      check("hlt_still_blocked", 32'(ready_in), 32'd0);

      // Async reset between edges clears halt, flags and sticky error
      @(posedge clk); #3 rst = 1'b1;
      #1 check("rst_async_halt", 32'(halted), 32'd0);
      check("rst_async_err", 32'(mem_err), 32'd0);
      check("rst_async_flags", 32'(flags), 32'd0);
      @(negedge clk); #1 rst = 1'b0;

      // Async reset in the middle of a memory request
      mem_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h0, len: 1});
      issue(OP_LD, 3'd5, 32'h500, 32'h0, 5'b10101, 1'b1);
      check("ld_flags", 32'(flags), 32'(5'b10101));
      #6 rst = 1'b1;
      #1 check("rst_mid_req", 32'(mem_req), 32'd0);
      check("rst_mid_flags", 32'(flags), 32'd0);
      check("rst_mid_addr", mem_addr, 32'd0);
      check("rst_mid_ready", 32'(ready_in), 32'd1);
      @(negedge clk); #1 rst = 1'b0;

      repeat (4) @(posedge clk);
      #1 check("wb_queue_empty", 32'(wb_q.size()), 32'd0);
      check("mem_queue_empty", 32'(mem_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
